// File: rtl/f_pc_pkg.sv
// Shared constants and state encodings for the fetch-stage PC unit.
package f_pc_pkg;

   localparam int unsigned PC_STEP = 4;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] DEF_IM_LO     = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_HI     = 32'h0000_6FFC;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } redir_state_e;

endpackage

// File: rtl/f_pc_redir_buf.sv
// Holds a branch redirect that arrives during a stall until the stall releases.
module f_pc_redir_buf
   import f_pc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             flush,
   output logic             pend_valid,
   output logic [WIDTH-1:0] pend_addr
);

   redir_state_e state, state_next;
   logic [WIDTH-1:0] addr_next;

   // State and held-address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_addr <= '0;
      end else begin
         state     <= state_next;
         pend_addr <= addr_next;
      end
   end

   // Flush drops the held redirect; a stalled branch captures (or overwrites) it;
   // any unstalled edge consumes or supersedes it.
   always_comb begin
      state_next = state;
      addr_next  = pend_addr;
      if (flush) begin
         state_next = IDLE;
      end else if (stall) begin
         if (br_valid) begin
            state_next = PEND;
            addr_next  = br_target;
         end
      end else begin
         state_next = IDLE;
      end
   end

   assign pend_valid = (state == PEND);

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage program counter with reset vector, exception entry, eret return,
// stall-tolerant branch redirect and fetch address error detection.
// Optional macro F_PC_PERF_EN adds stall_cnt/redir_cnt performance counters.
module f_pc_unit
   import f_pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
   parameter logic [WIDTH-1:0] IM_LO     = WIDTH'(DEF_IM_LO),
   parameter logic [WIDTH-1:0] IM_HI     = WIDTH'(DEF_IM_HI)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             fetch_adel,
   output logic             redir_pending
`ifdef F_PC_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      redir_cnt
`endif
);

   logic             pend_valid;
   logic [WIDTH-1:0] pend_addr;
   logic [WIDTH-1:0] pc_next;
   logic             redir_load;

   f_pc_redir_buf #(.WIDTH(WIDTH)) u_redir_buf (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .flush      (exc_req | eret_req),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr)
   );

   assign pc_plus4      = pc + WIDTH'(PC_STEP);
   assign redir_pending = pend_valid;
   assign fetch_adel    = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

   // Next-PC priority mux: exception, eret, stall hold, live branch, held branch, step.
   always_comb begin
      pc_next    = pc_plus4;
      redir_load = 1'b0;
      if (exc_req) begin
         pc_next    = EXC_VEC;
         redir_load = 1'b1;
      end else if (eret_req) begin
         pc_next    = epc;
         redir_load = 1'b1;
      end else if (stall) begin
         pc_next    = pc;
      end else if (br_valid) begin
         pc_next    = br_target;
         redir_load = 1'b1;
      end else if (pend_valid) begin
         pc_next    = pend_addr;
         redir_load = 1'b1;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (rst) pc <= RESET_VEC;
      else     pc <= pc_next;
   end

`ifdef F_PC_PERF_EN
   // Stall and redirect event counters, free-running with wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         redir_cnt <= '0;
      end else begin
         if (stall && !exc_req && !eret_req) stall_cnt <= stall_cnt + 32'd1;
         if (redir_load)                     redir_cnt <= redir_cnt + 32'd1;
      end
   end
`else
   logic unused_redir_load;
   assign unused_redir_load = redir_load;
`endif

endmodule

// File: doc/f_pc_unit.md
Name: f_pc_unit

Overview:
- Parametrised fetch-stage program counter; successor to the fixed 32-bit PC register.
- Adds a configurable reset vector, exception entry, eret return, and branch redirect.
- Holds a branch redirect that arrives while stalled and applies it once the stall releases.
- Flags fetch address errors (misaligned or out of instruction-memory range) for the exception pipeline.
- Sits in F stage; feeds IM and the F/D pipeline register.

Parameters:
- WIDTH, 32, PC width in bits (>= 16).
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; hold the PC.
- br_valid  in  1  branch/jump redirect request from D stage.
- br_target  in  WIDTH  redirect address.
- exc_req  in  1  exception taken; go to EXC_VEC.
- eret_req  in  1  eret committed; return to epc.
- epc  in  WIDTH  return address from CP0.
- pc  out  WIDTH  current fetch address.
- pc_plus4  out  WIDTH  pc + 4, wraps modulo 2^WIDTH.
- fetch_adel  out  1  pc[1:0] != 0, or pc < IM_LO, or pc > IM_HI.
- redir_pending  out  1  a held branch redirect is waiting.

Behaviour:
- Reset: one clk edge with rst=1 sets pc=RESET_VEC, pend_valid=0, pend_addr=0. This overrides every other input and is valid mid-stall or mid-pending.
- State machine: IDLE (pend_valid=0) and PEND (pend_valid=1). redir_pending = pend_valid.
- Next-PC priority, evaluated at each edge, highest first:
  1. exc_req: pc <= EXC_VEC; pend_valid <= 0. Applies even when stall=1.
  2. eret_req: pc <= epc; pend_valid <= 0. Applies even when stall=1.
  3. stall=1 and br_valid: pc holds; pend_addr <= br_target; pend_valid <= 1. A newer branch overwrites the held one.
  4. stall=1, no br_valid: pc holds; pending state unchanged.
  5. stall=0 and br_valid: pc <= br_target; pend_valid <= 0. The live request beats the held one.
  6. stall=0 and pend_valid: pc <= pend_addr; pend_valid <= 0.
  7. Otherwise: pc <= pc + 4.
- Latency: redirects take effect on the next edge (one cycle). A held redirect is applied on the first non-stalled edge.
- Arithmetic: pc + 4 is unsigned and truncated to WIDTH bits. 0xFFFF_FFFC wraps to 0x0000_0000, and fetch_adel must then assert.
- fetch_adel is combinational from pc only. The PC keeps advancing after an error; the exception logic flushes via exc_req.
- exc_req and eret_req together: exc_req wins.
- Target addresses are never masked or realigned; misalignment is reported through fetch_adel.

Optional Feature:
- Macro F_PC_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and redir_cnt[31:0].
  - stall_cnt increments on each edge with stall=1 and no exc_req/eret_req.
  - redir_cnt increments on each edge that loads br_target, pend_addr, EXC_VEC or epc.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds: default RESET_VEC, EXC_VEC, IM_LO and IM_HI constants; the PC_STEP=4 constant; IDLE/PEND state encodings.
- Sub-module f_pc_redir_buf: pending register plus state, inputs stall/br_valid/br_target/flush, outputs pend_valid/pend_addr. The top module holds the PC register, the priority mux, and the fetch_adel check.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; fetch_adel=0; redir_pending=0.
- At pc=0x3010: stall=1 for 2 cycles with br_valid=1, br_target=0x3100 in the first -> pc holds 0x3010, redir_pending=1. After stall drops -> pc=0x3100 next edge, redir_pending=0.
- stall=1 with br 0x3100, then br 0x3200 next cycle still stalled, then release -> pc=0x3200.
- At pc=0x3040: stall=1, pending set, exc_req=1 -> pc=0x4180, redir_pending=0. Then eret_req=1 with epc=0x3044 -> pc=0x3044.
- br_target=0x3002 -> fetch_adel=1. br_target=0x7000 -> fetch_adel=1. br_target=0x6FFC -> fetch_adel=0, and the next cycle at 0x7000 -> fetch_adel=1.
- rst=1 asserted while redir_pending=1 and stall=1 -> pc=0x3000, redir_pending=0 after the edge.
- With F_PC_PERF_EN: 3 stall cycles plus 1 branch -> stall_cnt=3, redir_cnt=1.
